// File: rtl/vertex_post_processor.sv
// Clip-space to screen-space vertex stage: input FIFO, iterative 1/w, perspective divide,
// viewport transform, and a held output handshake towards the rasterizer.
module vertex_post_processor #(
  parameter int DATAWIDTH     = 24,
  parameter int FRACBITS      = 13,
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 240,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic signed [DATAWIDTH-1:0] i_vertex [4],
  input  logic                        i_vertex_dv,
  input  logic                        i_vertex_last,
  output logic                        o_ready,
  output logic                        o_overflow,
  output logic signed [DATAWIDTH-1:0] o_screen_x,
  output logic signed [DATAWIDTH-1:0] o_screen_y,
  output logic signed [DATAWIDTH-1:0] o_depth,
  output logic                        o_clipped,
  output logic                        o_vertex_dv,
  input  logic                        i_ready,
  output logic                        o_finished
);

  localparam int W2 = 2 * DATAWIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(DATAWIDTH);
  localparam logic signed [DATAWIDTH-1:0] ONE  = DATAWIDTH'(1 << FRACBITS);
  localparam logic signed [DATAWIDTH-1:0] MAXV = {1'b0, {(DATAWIDTH-1){1'b1}}};
  localparam logic signed [DATAWIDTH-1:0] MINV = {1'b1, {(DATAWIDTH-1){1'b0}}};
  localparam logic [W2-1:0] DIVIDEND = W2'(1) << (2 * FRACBITS);
  localparam logic signed [W2-1:0] HALF_W = W2'(SCREEN_WIDTH / 2);
  localparam logic signed [W2-1:0] HALF_H = W2'(SCREEN_HEIGHT / 2);
  localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] SLACK = (PW+1)'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {IDLE, RECIP, SCALE, VIEWPORT, OUTPUT} state_t;

  function automatic logic signed [DATAWIDTH-1:0] sat(input logic signed [W2-1:0] v);
    if (&v[W2-1:DATAWIDTH-1] || ~|v[W2-1:DATAWIDTH-1]) return v[DATAWIDTH-1:0];
    return v[W2-1] ? MINV : MAXV;
  endfunction

  function automatic logic [DATAWIDTH:0] mag(input logic signed [DATAWIDTH-1:0] v);
    logic [DATAWIDTH:0] e;
    e = {v[DATAWIDTH-1], v};
    return v[DATAWIDTH-1] ? (~e + 1'b1) : e;
  endfunction

  state_t state_q, state_d;
  logic   pop, push;

  // Stage p0: input capture
  logic                        vld_p0, last_p0;
  logic signed [DATAWIDTH-1:0] vtx_p0 [4];

  always_ff @(posedge clk) begin
    if (!rstn) vld_p0 <= 1'b0;
    else       vld_p0 <= i_vertex_dv;
  end

  always_ff @(posedge clk) begin
    vtx_p0  <= i_vertex;
    last_p0 <= i_vertex_last;
  end

  logic signed [DATAWIDTH-1:0] mem [FIFO_DEPTH][4];
  logic                        mem_last [FIFO_DEPTH];
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic [PW:0]                 count;

  // A full FIFO still accepts a write when the same cycle frees a slot.
  assign push    = vld_p0 && (count != FULL || pop);
  assign o_ready = rstn && (count < SLACK);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]      <= vtx_p0;
      mem_last[wr_ptr] <= last_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (vld_p0 && !push) o_overflow <= 1'b1;
    end
  end

  logic signed [DATAWIDTH-1:0] head_x, head_y, head_z, head_w;
  logic                        head_last, head_wpos, head_clip, head_sat;

  assign head_x    = mem[rd_ptr][0];
  assign head_y    = mem[rd_ptr][1];
  assign head_z    = mem[rd_ptr][2];
  assign head_w    = mem[rd_ptr][3];
  assign head_last = mem_last[rd_ptr];
  assign head_wpos = !head_w[DATAWIDTH-1] && (|head_w);
  assign head_clip = !head_wpos || (mag(head_x) > mag(head_w)) ||
                     (mag(head_y) > mag(head_w)) || (mag(head_z) > mag(head_w));
  // Quotient exceeds the positive range exactly when |w| * 2^(DATAWIDTH-1) <= dividend.
  assign head_sat  = DIVIDEND >= (W2'(mag(head_w)) << (DATAWIDTH - 1));

  logic [IW-1:0] iter;

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (count != '0) begin
        pop     = 1'b1;
        state_d = head_wpos ? RECIP : VIEWPORT;
      end
      RECIP:    if (iter == IW'(DATAWIDTH - 1)) state_d = SCALE;
      SCALE:    state_d = VIEWPORT;
      VIEWPORT: state_d = OUTPUT;
      OUTPUT: if (i_ready) begin
        if (count != '0) begin
          pop     = 1'b1;
          state_d = head_wpos ? RECIP : VIEWPORT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: working vertex and restoring divider
  logic signed [DATAWIDTH-1:0] x_p1, y_p1, z_p1;
  logic                        last_p1, clip_p1, wpos_p1, sat_p1;
  logic [DATAWIDTH-1:0]        dvs_p1, rem_p1, dlo_p1, quo_p1;
  logic [DATAWIDTH:0]          trial;
  logic [DATAWIDTH-1:0]        sub;
  logic                        ge;

  assign trial = {rem_p1, dlo_p1[DATAWIDTH-1]};
  assign ge    = trial >= {1'b0, dvs_p1};
  assign sub   = DATAWIDTH'(trial - {1'b0, dvs_p1});

  always_ff @(posedge clk) begin
    if (!rstn) iter <= '0;
    else if (pop) iter <= '0;
    else if (state_q == RECIP) iter <= iter + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      x_p1    <= head_x;
      y_p1    <= head_y;
      z_p1    <= head_z;
      last_p1 <= head_last;
      clip_p1 <= head_clip;
      wpos_p1 <= head_wpos;
      sat_p1  <= head_sat;
      dvs_p1  <= head_w;
      rem_p1  <= DIVIDEND[W2-1:DATAWIDTH];
      dlo_p1  <= DIVIDEND[DATAWIDTH-1:0];
      quo_p1  <= '0;
    end else if (state_q == RECIP) begin
      rem_p1 <= ge ? sub : trial[DATAWIDTH-1:0];
      quo_p1 <= {quo_p1[DATAWIDTH-2:0], ge};
      dlo_p1 <= {dlo_p1[DATAWIDTH-2:0], 1'b0};
    end
  end

  // Stage p2: perspective divide (w is strictly positive on this path)
  logic signed [DATAWIDTH-1:0] recip;
  logic signed [W2-1:0]        prod_x, prod_y, prod_z;
  logic signed [DATAWIDTH-1:0] nx_p2, ny_p2, nz_p2;

  assign recip  = sat_p1 ? MAXV : quo_p1;
  assign prod_x = W2'(x_p1) * W2'(recip);
  assign prod_y = W2'(y_p1) * W2'(recip);
  assign prod_z = W2'(z_p1) * W2'(recip);

  always_ff @(posedge clk) begin
    if (state_q == SCALE) begin
      nx_p2 <= sat(prod_x >>> FRACBITS);
      ny_p2 <= sat(prod_y >>> FRACBITS);
      nz_p2 <= sat(prod_z >>> FRACBITS);
    end
  end

  // Stage p3: viewport transform into the held output registers
  logic signed [W2-1:0] vx, vy;

  assign vx = (W2'(nx_p2) + W2'(ONE)) * HALF_W;
  assign vy = (W2'(ONE) - W2'(ny_p2)) * HALF_H;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_screen_x <= '0;
      o_screen_y <= '0;
      o_depth    <= '0;
      o_clipped  <= 1'b0;
      o_finished <= 1'b0;
    end else begin
      if (state_q == VIEWPORT) begin
        o_screen_x <= wpos_p1 ? sat(vx) : '0;
        o_screen_y <= wpos_p1 ? sat(vy) : '0;
        o_depth    <= wpos_p1 ? nz_p2 : '0;
        o_clipped  <= clip_p1;
      end
      o_finished <= (state_q == OUTPUT) && i_ready && last_p1;
    end
  end

  assign o_vertex_dv = (state_q == OUTPUT);

endmodule
